tile_addr_gen: RTL and testbench
================================

Name: tile_addr_gen

Overview:
- Pixel-address stage between the VGA controller's scan coordinates and the tile image ROM of the 2048 display.
- Maps each (col_addr, row_addr) to a 12-bit ROM address: the tile image for that board cell's exponent, a gap colour or an outside colour.
- Holds the 4x4 board twice: a shadow copy written by game logic, and a display copy. The shadow is copied to the display at vsync, so the picture never tears.

Parameters:
- X0, 152, left edge of board frame (pixels)
- Y0, 72, top edge of board frame (lines)
- TILE, 64, tile edge on screen; must equal 16<<SCALE_SHIFT
- GAP, 16, gap width around and between tiles
- SCALE_SHIFT, 2, screen-pixel to image-pixel shift (16x16 image scaled 4x)

Ports:
- clk  in  1  pixel clock, same clock as the VGA controller
- clrn  in  1  asynchronous active-low reset
- col_addr  in  10  current scan column
- row_addr  in  9  current scan row
- vs  in  1  vertical sync from the VGA controller, active low
- wr_en  in  1  shadow board write strobe
- wr_cell  in  4  cell index = row*4+col; cell 0 is top-left
- wr_exp  in  4  tile exponent; 0 = empty, 1..11 = 2..2048, 12..15 spare
- commit_req  in  1  one-cycle request to copy shadow to display
- busy  out  1  commit pending
- commit_done  out  1  one-cycle pulse when the copy happens
- addr  out  12  ROM address {exp, v[3:0], u[3:0]}

Behaviour:
- Reset (clrn low, asynchronous):
  - both boards = 0 (all empty); busy=0; commit_done=0
  - addr=12'hF01; vs history register=1; pipeline registers cleared to the "outside" code
- Geometry:
  - board frame spans X0..X0+4*TILE+5*GAP-1 by Y0..Y0+4*TILE+5*GAP-1 (defaults 152..487, 72..407)
  - tile k (k=0..3) x-range starts at X0+GAP+k*(TILE+GAP) and is TILE pixels wide (defaults 168, 248, 328, 408); y-range uses Y0 the same way
  - locate the cell by comparator chain; no dividers
- Stage 1 (registered):
  - classify the pixel as tile / gap (inside frame, not in a tile) / outside
  - register cell index, u=(x-tile_x_start)>>SCALE_SHIFT and v=(y-tile_y_start)>>SCALE_SHIFT, each 0..15
- Stage 2 (registered):
  - tile: addr={disp[cell], v, u}
  - gap: 12'hF00
  - outside: 12'hF01
- Latency: exactly 2 clk from coordinates to addr; fully pipelined, one pixel per clk.
- Image 15 in the ROM is reserved. Entry F00 holds the gap colour, F01 the outside colour. Exponent 15 in a cell still renders image 15 normally.
- Shadow writes:
  - wr_en writes wr_exp to shadow[wr_cell] at the clk edge
  - allowed at any time, including while busy
- Commit:
  - commit_req sets pending (busy=1)
  - sync-fall event = vs sampled 1 on the previous clk and 0 on the current clk
  - at the first sync-fall while pending: all 16 display entries <= shadow in one cycle, pending clears, commit_done=1 for one cycle
- Boundaries:
  - commit_req while already pending: no effect; one commit, one commit_done
  - commit_req in the same cycle as the copy: copy occurs and pending re-arms (busy stays 1); a second copy happens at the next sync-fall
  - wr_en in the same cycle as the copy: display receives the old shadow value; shadow holds the new one; the new value appears after the next commit
  - sync-fall with nothing pending: no change
  - reset mid-pending: pending lost, both boards cleared, no commit_done
- Coordinates past 639/479 fall outside the frame and yield F01. The block needs no knowledge of blanking.

Test Plan:
- Reset; drive col=0,row=0 -> addr=12'hF01 from reset onward; busy=0, commit_done never pulses.
- Write cell 5 exp 3, pulse commit_req, toggle vs 1->0 -> busy high until sync-fall, then commit_done one pulse, busy 0. Then col=250,row=170 -> addr=12'h300 two clks later; col=311,row=231 -> 12'h3FF. The same coordinates before the commit -> 12'h000.
- Coordinates: col=240,row=170 -> 12'hF00 (gap); col=100,row=170 -> 12'hF01; col=487,row=407 -> F00; col=488 -> F01.
- Stream col 166..172 on consecutive clks, row=90, cell 0 exp 1 committed -> addr sequence lags by 2: F00, F00, 100, 100, 100, 100, 101.
- Write cell 0 exp 7 in the same cycle as the sync-fall copy, with commit_req also asserted -> display cell 0 keeps its old value and busy stays 1. Next sync-fall -> cell 0 renders 7xx; two commit_done pulses total.
- Pulse commit_req, then assert clrn low before vs falls -> busy=0 and boards empty; the following sync-fall produces no commit_done.

Source files
------------

// File: rtl/tile_addr_gen.sv
// tile_addr_gen: maps VGA scan coordinates to a tile ROM address; the board is double-buffered
// and the shadow copy is moved to the display copy on a vsync falling edge.
module tile_addr_gen #(
   parameter int X0          = 152,
   parameter int Y0          = 72,
   parameter int TILE        = 64,
   parameter int GAP         = 16,
   parameter int SCALE_SHIFT = 2
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic [9:0]  col_addr,
   input  logic [8:0]  row_addr,
   input  logic        vs,
   input  logic        wr_en,
   input  logic [3:0]  wr_cell,
   input  logic [3:0]  wr_exp,
   input  logic        commit_req,
   output logic        busy,
   output logic        commit_done,
   output logic [11:0] addr
);
   localparam int PITCH = TILE + GAP;
   localparam int FW = 4 * TILE + 5 * GAP;
   localparam logic [1:0] C_TILE = 2'd0;
   localparam logic [1:0] C_GAP = 2'd1;
   localparam logic [1:0] C_OUT = 2'd2;

   logic [15:0] cx, cy;
   logic [3:0] hx, hy;
   logic [3:0] dx [4];
   logic [3:0] dy [4];
   logic in_frame;
   logic [1:0] tx, ty;

   logic [1:0] cls_q, cls_d;
   logic [3:0] cell_q, cell_d, u_q, u_d, v_q, v_d;
   logic [11:0] addr_q, addr_d;
   logic [15:0][3:0] shad_q, shad_d, disp_q, disp_d;
   logic vs_q, vs_d, pend_q, pend_d, done_q, done_d;
   logic fall, copy;

   assign cx = {6'd0, col_addr};
   assign cy = {7'd0, row_addr};
   assign in_frame = (cx >= 16'(X0)) && (cx < 16'(X0 + FW)) && (cy >= 16'(Y0)) && (cy < 16'(Y0 + FW));

   // One comparator pair per tile column/row; offsets are only meaningful where the hit is set.
   for (genvar i = 0; i < 4; i++) begin : g_tile
      localparam logic [15:0] XS = 16'(X0 + GAP + i * PITCH);
      localparam logic [15:0] YS = 16'(Y0 + GAP + i * PITCH);
      assign hx[i] = (cx >= XS) && (cx < XS + 16'(TILE));
      assign hy[i] = (cy >= YS) && (cy < YS + 16'(TILE));
      assign dx[i] = 4'((cx - XS) >> SCALE_SHIFT);
      assign dy[i] = 4'((cy - YS) >> SCALE_SHIFT);
   end

   always_comb begin
      tx = '0;
      ty = '0;
      for (int k = 0; k < 4; k++) begin
         if (hx[k]) tx = 2'(k);
         if (hy[k]) ty = 2'(k);
      end
      cls_d = !in_frame ? C_OUT : (|hx && |hy) ? C_TILE : C_GAP;
      cell_d = {ty, tx};
      u_d = dx[tx];
      v_d = dy[ty];
      addr_d = cls_q == C_TILE ? {disp_q[cell_q], v_q, u_q} : cls_q == C_GAP ? 12'hF00 : 12'hF01;
   end

   always_comb begin
      vs_d = vs;
      fall = vs_q & ~vs;
      copy = pend_q & fall;
      pend_d = commit_req | (pend_q & ~fall);
      done_d = copy;
      disp_d = copy ? shad_q : disp_q;
      shad_d = shad_q;
      if (wr_en) shad_d[wr_cell] = wr_exp;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cls_q <= C_OUT;
         cell_q <= '0;
         u_q <= '0;
         v_q <= '0;
         addr_q <= 12'hF01;
         shad_q <= '0;
         disp_q <= '0;
         vs_q <= 1'b1;
         pend_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         cls_q <= cls_d;
         cell_q <= cell_d;
         u_q <= u_d;
         v_q <= v_d;
         addr_q <= addr_d;
         shad_q <= shad_d;
         disp_q <= disp_d;
         vs_q <= vs_d;
         pend_q <= pend_d;
         done_q <= done_d;
      end
   end

   assign busy = pend_q;
   assign commit_done = done_q;
   assign addr = addr_q;
endmodule

// File: tb/tb_tile_addr_gen.sv
// tb_tile_addr_gen: directed and random checks of tile_addr_gen against an arithmetic board model.
module tb_tile_addr_gen;
   localparam int X0 = 152, Y0 = 72, TILE = 64, GAP = 16, SH = 2;
   localparam int P = TILE + GAP, FW = 4 * TILE + 5 * GAP;

   logic clk = 1'b0, clrn, vs, wr_en, commit_req, busy, commit_done;
   logic [9:0] col;
   logic [8:0] row;
   logic [3:0] wr_cell, wr_exp;
   logic [11:0] addr;
   int n_chk = 0, n_pass = 0, n_done = 0;

   int m_shad [16];
   int m_disp [16];
   bit m_pend, m_done, m_vs, m_fall;
   logic [11:0] m_addr;
   int p_col, p_row;

   always #5 clk = ~clk;

   tile_addr_gen dut (
      .clk(clk), .clrn(clrn), .col_addr(col), .row_addr(row), .vs(vs),
      .wr_en(wr_en), .wr_cell(wr_cell), .wr_exp(wr_exp), .commit_req(commit_req),
      .busy(busy), .commit_done(commit_done), .addr(addr)
   );

   function automatic logic [11:0] ref_addr(input int x, input int y);
      int rx, ry;
      if (x < X0 || x >= X0 + FW || y < Y0 || y >= Y0 + FW) return 12'hF01;
      rx = x - X0 - GAP;
      ry = y - Y0 - GAP;
      if (rx < 0 || ry < 0 || rx % P >= TILE || ry % P >= TILE) return 12'hF00;
      return {4'(m_disp[(ry / P) * 4 + rx / P]), 4'((ry % P) >> SH), 4'((rx % P) >> SH)};
   endfunction

   always @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         foreach (m_shad[i]) begin
            m_shad[i] = 0;
            m_disp[i] = 0;
         end
         m_pend = 0;
         m_done = 0;
         m_vs = 1;
         m_addr = 12'hF01;
         p_col = 1023;
         p_row = 511;
      end else begin
         m_fall = m_vs && !vs;
         m_addr = ref_addr(p_col, p_row);
         p_col = int'(col);
         p_row = int'(row);
         m_done = m_pend && m_fall;
         if (m_done) m_disp = m_shad;
         m_pend = commit_req || (m_pend && !m_fall);
         if (wr_en) m_shad[wr_cell] = int'(wr_exp);
         m_vs = vs;
      end
   end

   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      if (commit_done) n_done++;
      check("addr", addr, m_addr);
      check("busy", 12'(busy), 12'(m_pend));
      check("done", 12'(commit_done), 12'(m_done));
   endtask

   task automatic setxy(input int c, input int r);
      col = 10'(c);
      row = 9'(r);
      tick;
      tick;
   endtask

   task automatic wr(input int c, input int e);
      wr_en = 1'b1;
      wr_cell = 4'(c);
      wr_exp = 4'(e);
      tick;
      wr_en = 1'b0;
   endtask

   task automatic do_commit;
      commit_req = 1'b1;
      tick;
      commit_req = 1'b0;
      tick;
      vs = 1'b0;
      tick;
      vs = 1'b1;
      tick;
   endtask

   logic [11:0] sq [7];

   initial begin
      sq = '{12'hF00, 12'hF00, 12'h100, 12'h100, 12'h100, 12'h100, 12'h101};
      clrn = 1'b1; vs = 1'b1; col = '0; row = '0;
      wr_en = 1'b0; wr_cell = '0; wr_exp = '0; commit_req = 1'b0;
      #1 clrn = 1'b0;
      repeat (3) tick;
      check("rst_addr", addr, 12'hF01);
      check("rst_busy", 12'(busy), 12'd0);
      clrn = 1'b1;
      setxy(0, 0);
      check("origin", addr, 12'hF01);

      wr(5, 3);
      setxy(250, 170);
      check("pre_commit", addr, 12'h000);
      commit_req = 1'b1;
      tick;
      commit_req = 1'b0;
      check("pend_busy", 12'(busy), 12'd1);
      tick;
      check("still_old", addr, 12'h000);
      vs = 1'b0;
      tick;
      check("copy_done", 12'(commit_done), 12'd1);
      check("copy_busy", 12'(busy), 12'd0);
      vs = 1'b1;
      tick;
      check("done_once", 12'(commit_done), 12'd0);
      check("new_disp", addr, 12'h300);
      setxy(311, 231);
      check("tile_end", addr, 12'h3FF);
      setxy(240, 170);
      check("gap", addr, 12'hF00);
      setxy(100, 170);
      check("outside", addr, 12'hF01);
      setxy(487, 407);
      check("frame_edge", addr, 12'hF00);
      setxy(488, 407);
      check("past_frame", addr, 12'hF01);

      wr(0, 1);
      do_commit;
      row = 9'd90;
      for (int i = 0; i < 8; i++) begin
         if (i < 7) col = 10'(166 + i);
         tick;
         if (i >= 1) check("stream", addr, sq[i-1]);
      end

      n_done = 0;
      commit_req = 1'b1;
      tick;
      vs = 1'b0; wr_en = 1'b1; wr_cell = 4'd0; wr_exp = 4'd7;
      tick;
      check("same_done", 12'(commit_done), 12'd1);
      check("rearm_busy", 12'(busy), 12'd1);
      wr_en = 1'b0; commit_req = 1'b0; vs = 1'b1;
      setxy(170, 90);
      check("old_cell0", addr, 12'h100);
      vs = 1'b0;
      tick;
      vs = 1'b1;
      tick;
      check("new_cell0", addr, 12'h700);
      check("two_dones", 12'(n_done), 12'd2);
      check("idle_busy", 12'(busy), 12'd0);

      commit_req = 1'b1;
      tick;
      commit_req = 1'b0;
      tick;
      clrn = 1'b0;
      #2;
      check("async_busy", 12'(busy), 12'd0);
      check("async_addr", addr, 12'hF01);
      tick;
      clrn = 1'b1;
      n_done = 0;
      tick;
      vs = 1'b0;
      tick;
      vs = 1'b1;
      tick;
      tick;
      check("no_done", 12'(n_done), 12'd0);
      setxy(170, 90);
      check("cleared", addr, 12'h000);

      repeat (3000) begin
         if ($urandom % 2 == 0) begin
            col = 10'($urandom_range(140, 500));
            row = 9'($urandom_range(60, 420));
         end else begin
            col = 10'($urandom);
            row = 9'($urandom);
         end
         wr_en = ($urandom % 5 == 0);
         wr_cell = 4'($urandom);
         wr_exp = 4'($urandom);
         commit_req = ($urandom % 16 == 0);
         vs = ($urandom % 6 != 0);
         tick;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
